// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal router input buffer: packet layout,
// virtual-channel encoding and the hop-field update applied on the way out.
// Packets use MSB-first bit numbering: bit 0 is the leftmost (most significant) bit.
package cardinal_pkg;

    localparam int PAC_WIDTH = 64;
    localparam int VC_BIT    = 0;
    localparam int HOP_LSB   = 8;
    localparam int HOP_W     = 8;
    localparam int PAY_LSB   = 32;
    localparam int PAY_MSB   = 63;

    typedef logic [0:PAC_WIDTH-1] pkt_t;
    typedef logic [0:HOP_W-1]     hop_t;

    typedef enum logic {
        VC_EVEN = 1'b0,
        VC_ODD  = 1'b1
    } vc_e;

    // Virtual channel a packet travels on.
    function automatic vc_e vc_of(input pkt_t pkt);
        return vc_e'(pkt[VC_BIT]);
    endfunction

    // One hop consumed: the hop field is logically shifted right by one.
    // Zero stays zero; every other bit passes through untouched.
    function automatic pkt_t hop_update(input pkt_t pkt);
        pkt_t res;
        hop_t hop;
        hop = pkt[HOP_LSB +: HOP_W];
        res = pkt;
        res[HOP_LSB +: HOP_W] = hop >> 1;
        return res;
    endfunction

endpackage

// File: rtl/cardinal_input_buffer_if.sv
// Link-side and arbiter-side handshake of the cardinal input buffer.
// slave: the buffer itself; master: whoever drives the link and the grant.
interface cardinal_input_buffer_if;
    import cardinal_pkg::*;

    logic up_si;
    logic up_ri;
    pkt_t up_di;
    logic out_vld;
    pkt_t out_data;
    logic out_gnt;

    modport slave (
        input  up_si,
        input  up_di,
        input  out_gnt,
        output up_ri,
        output out_vld,
        output out_data
    );

    modport master (
        output up_si,
        output up_di,
        output out_gnt,
        input  up_ri,
        input  out_vld,
        input  out_data
    );

endinterface

// File: rtl/cardinal_vc_slot.sv
// One-entry packet holder for a single virtual channel.
// A write fills the entry, a read strobe frees it; the parent guarantees the
// two never target the same slot in the same cycle, write wins if they did.
module cardinal_vc_slot
    import cardinal_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  pkt_t wr_data,
    input  logic rd_en,
    output logic full,
    output pkt_t data
);

    // Occupancy flag and stored packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr_en) begin
            full <= 1'b1;
            data <= wr_data;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_input_buffer.sv
// Router input buffer: one packet per virtual channel (VC0 even, VC1 odd).
// net_polarity selects the VC the link may write this cycle; the opposite VC
// is the one presented to the arbiter, so a slot is never written and drained
// together. Optional accepted-packet counter: define CARDINAL_IBUF_PKT_CNT_EN.
module cardinal_input_buffer
    import cardinal_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic net_polarity,
    cardinal_input_buffer_if.slave bus,
`ifdef CARDINAL_IBUF_PKT_CNT_EN
    output logic [0:15] pkt_cnt,
`endif
    output logic proto_err
);

    logic [1:0] full;
    pkt_t       slot_data [2];
    logic [1:0] wr_en;
    logic [1:0] rd_en;
    logic       send_ok;
    logic       vc_match;
    logic       accept;
    logic       vc_err;
    logic       drain;

    // Link side: only the external-phase slot is offered to upstream.
    assign bus.up_ri = ~full[net_polarity];
    assign send_ok   = bus.up_si & bus.up_ri;
    assign vc_match  = (vc_of(bus.up_di) == vc_e'(net_polarity));
    assign accept    = send_ok & vc_match;
    assign vc_err    = send_ok & ~vc_match;
    assign wr_en     = {accept & net_polarity, accept & ~net_polarity};

    // Arbiter side: the internal-phase slot, hop already consumed.
    assign bus.out_vld  = full[~net_polarity];
    assign drain        = bus.out_gnt & bus.out_vld;
    assign rd_en        = {drain & ~net_polarity, drain & net_polarity};
    assign bus.out_data = bus.out_vld ? hop_update(slot_data[~net_polarity]) : '0;

    cardinal_vc_slot u_slot_vc0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[0]),
        .wr_data (bus.up_di),
        .rd_en   (rd_en[0]),
        .full    (full[0]),
        .data    (slot_data[0])
    );

    cardinal_vc_slot u_slot_vc1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en[1]),
        .wr_data (bus.up_di),
        .rd_en   (rd_en[1]),
        .full    (full[1]),
        .data    (slot_data[1])
    );

    // A packet offered on the wrong VC is dropped and flagged until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (vc_err) begin
            proto_err <= 1'b1;
        end
    end

`ifdef CARDINAL_IBUF_PKT_CNT_EN
    // Free-running count of accepted packets, wraps at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt <= '0;
        end else if (accept) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cardinal_input_buffer.sv
// Self-checking bench for cardinal_input_buffer: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_cardinal_input_buffer;
    import cardinal_pkg::*;

    logic clk;
    logic reset;
    logic net_polarity;
    logic proto_err;
`ifdef CARDINAL_IBUF_PKT_CNT_EN
    logic [0:15] pkt_cnt;
    logic [15:0] act_cnt;
`endif

    cardinal_input_buffer_if bus ();

    cardinal_input_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .net_polarity (net_polarity),
        .bus          (bus),
`ifdef CARDINAL_IBUF_PKT_CNT_EN
        .pkt_cnt      (pkt_cnt),
`endif
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: what each VC currently holds
    bit   m_full [2];
    pkt_t m_slot [2];
    bit   m_err;

    logic act_ri, act_vld, act_err;
    pkt_t act_data;
    logic exp_ri, exp_vld, exp_err;
    pkt_t exp_data;

    typedef struct {
        logic pol;
        logic si;
        pkt_t di;
        logic gnt;
        logic ri;
        logic vld;
        pkt_t data;
        logic err;
    } vec_t;

    vec_t tbl [12];

    localparam pkt_t P1  = {1'b1, 7'h00, 8'h0C, 16'h0000, 32'hDEADBEEF};
    localparam pkt_t P1O = {1'b1, 7'h00, 8'h06, 16'h0000, 32'hDEADBEEF};
    localparam pkt_t P2  = {1'b0, 7'h15, 8'h00, 16'hA5A5, 32'h12345678};
    localparam pkt_t P3  = {1'b0, 7'h00, 8'hFF, 16'h0001, 32'hCAFEF00D};
    localparam pkt_t P3O = {1'b0, 7'h00, 8'h7F, 16'h0001, 32'hCAFEF00D};
    localparam pkt_t Z   = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // hop consumed: numeric halving of the hop byte, everything else kept
    function automatic pkt_t exp_out(input pkt_t d);
        logic [7:0] h;
        h = d[8:15];
        h = h / 8'd2;
        return {d[0:7], h, d[16:63]};
    endfunction

    function automatic pkt_t mk_pkt(input logic vc);
        pkt_t d;
        d = {$urandom, $urandom};
        d[0] = vc;
        return d;
    endfunction

    function automatic void model_clear();
        m_full[0] = 0;
        m_full[1] = 0;
        m_slot[0] = '0;
        m_slot[1] = '0;
        m_err = 0;
    endfunction

    // one clock: drive at edge+1, sample at negedge, advance model at edge, flip phase
    task automatic cycle(input logic si, input pkt_t di, input logic gnt);
        int  p;
        int  q;
        bit  take;
        bit  drop;
        bit  pop;
        bus.up_si   = si;
        bus.up_di   = di;
        bus.out_gnt = gnt;
        p = net_polarity ? 1 : 0;
        q = 1 - p;
        @(negedge clk);
        act_ri   = bus.up_ri;
        act_vld  = bus.out_vld;
        act_data = bus.out_data;
        act_err  = proto_err;
`ifdef CARDINAL_IBUF_PKT_CNT_EN
        act_cnt  = pkt_cnt;
`endif
        exp_ri   = !m_full[p];
        exp_vld  = m_full[q];
        exp_data = m_full[q] ? exp_out(m_slot[q]) : '0;
        exp_err  = m_err;
        @(posedge clk);
        take = si && !m_full[p] && (di[0] == net_polarity);
        drop = si && !m_full[p] && (di[0] != net_polarity);
        pop  = gnt && m_full[q];
        if (take) begin
            m_full[p] = 1;
            m_slot[p] = di;
        end
        if (drop) m_err = 1;
        if (pop) m_full[q] = 0;
        #1;
        net_polarity = ~net_polarity;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".up_ri"},    64'(act_ri),  64'(exp_ri));
        check({tag, ".out_vld"},  64'(act_vld), 64'(exp_vld));
        check({tag, ".out_data"}, act_data,     exp_data);
        check({tag, ".proto_err"}, 64'(act_err), 64'(exp_err));
    endtask

    task automatic apply_reset();
        bus.up_si   = 1'b0;
        bus.up_di   = '0;
        bus.out_gnt = 1'b0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t exp_q [$];
        pkt_t d;
        int   got;

        tbl[0]  = '{1'b1, 1'b1, P1, 1'b1, 1'b1, 1'b0, Z,   1'b0};
        tbl[1]  = '{1'b0, 1'b0, Z,  1'b1, 1'b1, 1'b1, P1O, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, Z,  1'b0, 1'b1, 1'b0, Z,   1'b0};
        tbl[3]  = '{1'b0, 1'b1, P2, 1'b0, 1'b1, 1'b0, Z,   1'b0};
        tbl[4]  = '{1'b1, 1'b0, Z,  1'b0, 1'b1, 1'b1, P2,  1'b0};
        tbl[5]  = '{1'b0, 1'b1, P3, 1'b1, 1'b0, 1'b0, Z,   1'b0};
        tbl[6]  = '{1'b1, 1'b0, Z,  1'b0, 1'b1, 1'b1, P2,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, P3, 1'b0, 1'b0, 1'b0, Z,   1'b0};
        tbl[8]  = '{1'b1, 1'b0, Z,  1'b1, 1'b1, 1'b1, P2,  1'b0};
        tbl[9]  = '{1'b0, 1'b1, P3, 1'b0, 1'b1, 1'b0, Z,   1'b0};
        tbl[10] = '{1'b1, 1'b0, Z,  1'b1, 1'b1, 1'b1, P3O, 1'b0};
        tbl[11] = '{1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, Z,   1'b0};

        // power-up reset
        reset        = 1'b0;
        net_polarity = 1'b0;
        bus.up_si    = 1'b0;
        bus.up_di    = '0;
        bus.out_gnt  = 1'b0;
        model_clear();
        #3;
        check("por.up_ri",     64'(bus.up_ri),   64'd1);
        check("por.out_vld",   64'(bus.out_vld), 64'd0);
        check("por.out_data",  bus.out_data,     64'd0);
        check("por.proto_err", 64'(proto_err),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // directed table: pass-through, hop update, back-pressure, ignored grant
        for (int i = 0; i < 12; i++) begin
            net_polarity = tbl[i].pol;
            cycle(tbl[i].si, tbl[i].di, tbl[i].gnt);
            check($sformatf("tbl%0d.up_ri", i),     64'(act_ri),  64'(tbl[i].ri));
            check($sformatf("tbl%0d.out_vld", i),   64'(act_vld), 64'(tbl[i].vld));
            check($sformatf("tbl%0d.out_data", i),  act_data,     tbl[i].data);
            check($sformatf("tbl%0d.proto_err", i), 64'(act_err), 64'(tbl[i].err));
        end

        // interleaved VCs at full rate, in-order delivery
        got = 0;
        for (int i = 0; i < 21; i++) begin
            if (i < 20) begin
                d = mk_pkt(net_polarity);
                exp_q.push_back(d);
                cycle(1'b1, d, 1'b1);
                check($sformatf("ilv%0d.up_ri", i), 64'(act_ri), 64'd1);
            end else begin
                cycle(1'b0, Z, 1'b1);
            end
            if (i > 0) begin
                check($sformatf("ilv%0d.out_vld", i), 64'(act_vld), 64'd1);
                if (act_vld === 1'b1 && exp_q.size() > 0) begin
                    check($sformatf("ilv%0d.out_data", i), act_data, exp_out(exp_q.pop_front()));
                    got++;
                end
            end
        end
        check("ilv.delivered", 64'(got), 64'd20);

        // VC mismatch: dropped, sticky error, slots untouched
        if (net_polarity == 1'b0) cycle(1'b0, Z, 1'b0);
        cycle(1'b1, P2, 1'b0);
        check("perr.before", 64'(act_err), 64'd0);
        cycle(1'b0, Z, 1'b0);
        check("perr.vld1", 64'(act_vld), 64'd0);
        check("perr.set",  64'(act_err), 64'd1);
        cycle(1'b0, Z, 1'b1);
        check("perr.vld2",   64'(act_vld), 64'd0);
        check("perr.ri",     64'(act_ri),  64'd1);
        check("perr.sticky", 64'(act_err), 64'd1);

`ifdef CARDINAL_IBUF_PKT_CNT_EN
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk_pkt(net_polarity), 1'b1);
        cycle(1'b1, mk_pkt(~net_polarity), 1'b1);
        cycle(1'b0, Z, 1'b1);
        check("cnt.three", 64'(act_cnt), 64'd3);
        for (int i = 0; i < 65532; i++) cycle(1'b1, mk_pkt(net_polarity), 1'b1);
        cycle(1'b0, Z, 1'b1);
        check("cnt.max", 64'(act_cnt), 64'hFFFF);
        cycle(1'b1, mk_pkt(net_polarity), 1'b1);
        cycle(1'b0, Z, 1'b1);
        check("cnt.wrap", 64'(act_cnt), 64'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic si;
            logic vc;
            si = ($urandom % 4) != 0;
            vc = (($urandom % 8) == 0) ? ~net_polarity : net_polarity;
            cycle(si, mk_pkt(vc), 1'($urandom % 2));
            check_model($sformatf("rnd%0d", i));
        end

        // asynchronous reset with both slots occupied
        cycle(1'b1, mk_pkt(net_polarity), 1'b0);
        cycle(1'b1, mk_pkt(net_polarity), 1'b0);
        cycle(1'b1, mk_pkt(net_polarity), 1'b0);
        check("rst.pre_vld", 64'(act_vld), 64'd1);
        check("rst.pre_ri",  64'(act_ri),  64'd0);
        bus.up_si   = 1'b0;
        bus.out_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst.up_ri",     64'(bus.up_ri),   64'd1);
        check("rst.out_vld",   64'(bus.out_vld), 64'd0);
        check("rst.out_data",  bus.out_data,     64'd0);
        check("rst.proto_err", 64'(proto_err),   64'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, Z, 1'b0);
            check($sformatf("rst.post%0d.vld", i), 64'(act_vld), 64'd0);
            check($sformatf("rst.post%0d.ri", i),  64'(act_ri),  64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cardinal_input_buffer.md
Name: cardinal_input_buffer

Overview:
- Router-side input channel buffer that consumes the NIC/neighbour link output (si/ri/di) and holds one 64-bit packet per virtual channel (VC0 even, VC1 odd).
- Sits between the link and the router's output arbiter/crossbar.
- Uses net_polarity to keep the external (link write) and internal (arbiter drain) phases on opposite VCs, so a slot is never written and drained in the same cycle.

Parameters:
- PAC_WIDTH, 64, packet width; bit 0 = VC, bits 8:15 = hop field, bits 32:63 = payload
- HOP_LSB, 8, first bit of hop field (MSB-first indexing)
- HOP_W, 8, hop field width

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- net_polarity  input  1  global phase, toggles every cycle
- up_si  input  1  upstream send strobe
- up_ri  output  1  ready to upstream
- up_di  input  PAC_WIDTH  upstream packet
- out_vld  output  1  packet available to arbiter
- out_data  output  PAC_WIDTH  packet to crossbar, hop field already updated
- out_gnt  input  1  arbiter consumes the presented packet this cycle
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Phases:
  - External phase accepts only VC == net_polarity.
  - Internal phase presents only VC == ~net_polarity.
- up_ri = ~full[net_polarity]. It is combinational, so up_ri is 1 immediately after reset.
- Accept: at posedge with up_si & up_ri & (up_di[0] == net_polarity), the packet is written to slot[net_polarity] and full is set.
- Latency: a packet accepted at edge k is presented from cycle k+1, because polarity has flipped.
- Presentation:
  - out_vld = full[~net_polarity].
  - out_data = slot[~net_polarity] with the hop field logically shifted right by 1; all-zero when out_vld = 0.
- Dequeue: at posedge with out_gnt & out_vld, full[~net_polarity] is cleared.
- Ignored grants: out_gnt while out_vld = 0 is ignored, with no state change.
- Hop field: a hop field of 0 is passed as 0. Payload and other header bits pass unchanged.
- Throughput: each VC slot has at most 1 packet per 2 cycles; the combined rate is 1 packet/cycle.
- Full slot: up_si held while up_ri = 0 is not accepted and up_di is not sampled. Upstream must hold its packet and retry.
- VC mismatch: up_si & up_ri with up_di[0] != net_polarity:
  - the packet is dropped;
  - proto_err is set (sticky until reset);
  - slots are unaffected.
- Simultaneous events: a write and a drain in the same cycle always target different slots, so both happen independently.
- Reset:
  - Asynchronously clears full[1:0], slot data, and proto_err.
  - A packet mid-transfer during reset is lost.
  - Outputs during reset: up_ri = 1, out_vld = 0, out_data = 0, proto_err = 0.

Optional Feature:
- Macro CARDINAL_IBUF_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt [0:15], the count of accepted packets.
  - Increments on each accept and wraps 0xFFFF -> 0x0000.
  - Reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cardinal_pkg holds:
  - PAC_WIDTH;
  - field offsets (VC bit, hop LSB/width, payload range);
  - the hop-update helper function.
- One sub-module, cardinal_vc_slot (one-entry register and full flag with wr/rd strobes), instantiated twice by VC.

Test Plan:
1. Reset:
   - Stimulus: reset = 0 mid-run with both slots full.
   - Response: up_ri = 1, out_vld = 0, out_data = 0, proto_err = 0 asynchronously.
2. Basic pass and hop update:
   - Stimulus: with polarity = 1, send up_di = {1'b1, 7'h00, 8'h0C, 16'h0, 32'hDEADBEEF}; out_gnt = 1.
   - Response: next cycle out_vld = 1 and out_data hop = 8'h06, payload DEADBEEF; the slot is empty afterwards.
3. Back-pressure:
   - Stimulus: hold out_gnt = 0 and fill VC0.
   - Response: up_ri = 0 in every polarity-0 cycle.
   - Stimulus: assert out_gnt for one cycle.
   - Response: VC0 is freed; the next polarity-0 cycle has up_ri = 1, and the held packet is accepted.
4. Interleaved VCs:
   - Stimulus: alternate VC1 and VC0 packets every cycle with out_gnt = 1.
   - Response: one packet out per cycle, in order, no loss.
5. Protocol error:
   - Stimulus: send a VC0 packet while polarity = 1.
   - Response: no slot written, out_vld stays 0, proto_err = 1 until reset.
6. CARDINAL_IBUF_PKT_CNT_EN:
   - Stimulus: 3 accepts, then 1 rejected (VC mismatch).
   - Response: pkt_cnt = 3.
   - Stimulus: preload the counter to 0xFFFF, then 1 accept.
   - Response: pkt_cnt = 0.
